// File: rtl/microprocessor.sv
// 16-bit registered ALU: eight unsigned operations per clock,
// result and carry/zero/div-by-zero flags registered together.
module microprocessor (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [15:0] ALU_Result,
  output logic        carry,
  output logic        zero,
  output logic        div_by_zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  logic [15:0] result_d, result_q;
  logic        carry_d, carry_q;
  logic        zero_d, zero_q;
  logic        dbz_d, dbz_q;

  logic [16:0] sum;
  logic [16:0] diff;
  logic [31:0] prod;
  logic [15:0] quot;
  logic        b_zero;

  // Widened arithmetic so the top bit carries the flag directly.
  always_comb begin
    sum    = {1'b0, A} + {1'b0, B};
    diff   = {1'b0, A} - {1'b0, B};
    prod   = {16'h0, A} * {16'h0, B};
    b_zero = (B == 16'h0);
    quot   = b_zero ? 16'hFFFF : A / B;
  end

  // Select the operation result and its flags for this edge.
  always_comb begin
    result_d = 16'h0;
    carry_d  = 1'b0;
    dbz_d    = 1'b0;
    unique case (Opcode)
      OP_ADD: begin
        result_d = sum[15:0];
        carry_d  = sum[16];
      end
      OP_SUB: begin
        result_d = diff[15:0];
        carry_d  = diff[16];
      end
      OP_MUL: begin
        result_d = prod[15:0];
        carry_d  = |prod[31:16];
      end
      OP_DIV: begin
        result_d = quot;
        dbz_d    = b_zero;
      end
      OP_AND: result_d = A & B;
      OP_OR:  result_d = A | B;
      OP_XOR: result_d = A ^ B;
      OP_NOT: result_d = ~A;
      default: result_d = 16'h0;
    endcase
    zero_d = (result_d == 16'h0);
  end

  // Output register; reset wins over any operation on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 16'h0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
    end
  end

  assign ALU_Result  = result_q;
  assign carry       = carry_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_microprocessor.sv
// Scoreboard bench for the registered ALU: a driver pushes
// model results per edge, a monitor pops and compares them.
module tb_microprocessor;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        z;
    logic        d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  Opcode = 3'd0;
  logic [15:0] A = 16'h0;
  logic [15:0] B = 16'h0;
  logic [15:0] ALU_Result;
  logic        carry, zero, div_by_zero;

  exp_t exp_q[$];
  exp_t cur_exp;
  bit   cur_valid = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  microprocessor dut (
    .clk(clk),
    .rst(rst),
    .Opcode(Opcode),
    .A(A),
    .B(B),
    .ALU_Result(ALU_Result),
    .carry(carry),
    .zero(zero),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(bit r, int op, int a, int b);
    exp_t e;
    longint v;
    e = '0;
    if (r) return e;
    v = 0;
    case (op)
      0: begin v = a + b; e.c = (v > 65535); end
      1: begin v = a - b; e.c = (a < b); if (v < 0) v += 65536; end
      2: begin v = longint'(a) * b; e.c = (v >= 65536); end
      3: begin
        if (b == 0) begin v = 65535; e.d = 1; end
        else v = a / b;
      end
      4: v = a & b;
      5: v = a | b;
      6: v = a ^ b;
      default: v = 65535 - a;
    endcase
    v = v % 65536;
    e.r = v[15:0];
    e.z = (v == 0);
    return e;
  endfunction

  task automatic issue(bit r, int op, int a, int b);
    @(negedge clk);
    rst = r;
    Opcode = op[2:0];
    A = a[15:0];
    B = b[15:0];
    exp_q.push_back(model(r, op, a, b));
  endtask

  function automatic bit outs_ok(exp_t e);
    return ALU_Result === e.r && carry === e.c &&
           zero === e.z && div_by_zero === e.d;
  endfunction

  // Monitor: every edge with a pending expectation is checked.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        cur_exp = exp_q.pop_front();
        cur_valid = 1;
        n_checks++;
        if (!outs_ok(cur_exp)) begin
          n_fail++;
          $display("FAIL edge_result got r=%h c=%b z=%b d=%b want r=%h c=%b z=%b d=%b",
                   ALU_Result, carry, zero, div_by_zero,
                   cur_exp.r, cur_exp.c, cur_exp.z, cur_exp.d);
        end
      end
    end
  end

  // Wiggle operands between edges; outputs must not move.
  task automatic glitch();
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      A = 16'($urandom);
      B = 16'($urandom);
      Opcode = 3'($urandom);
      #1;
      if (cur_valid) begin
        n_checks++;
        if (!outs_ok(cur_exp)) begin
          n_fail++;
          $display("FAIL glitch_hold got r=%h c=%b z=%b d=%b want r=%h",
                   ALU_Result, carry, zero, div_by_zero, cur_exp.r);
        end
      end
    end
  endtask

  function automatic int pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 65535;
      2: return int'($urandom_range(0, 15));
      default: return int'($urandom_range(0, 65535));
    endcase
  endfunction

  initial begin
    int guard;
    issue(1, 2, 16'h1234, 16'h5678);
    issue(1, 0, 16'hFFFF, 16'h0001);
    issue(0, 0, 3, 1);
    issue(0, 1, 3, 1);
    issue(0, 2, 3, 2);
    issue(0, 3, 4, 2);
    issue(0, 4, 3, 1);
    issue(0, 5, 3, 1);
    issue(0, 6, 3, 1);
    issue(0, 7, 3, 1);
    issue(0, 0, 16'hFFFF, 1);
    issue(0, 1, 0, 1);
    issue(0, 2, 16'h0100, 16'h0100);
    issue(0, 3, 7, 2);
    issue(0, 3, 16'h1234, 0);
    issue(0, 0, 5, 6);
    issue(0, 0, 3, 1);
    issue(1, 2, 3, 2);
    issue(0, 2, 3, 2);
    issue(0, 6, 16'hA5A5, 16'h0F0F);
    glitch();
    issue(0, 3, 16'hFFFF, 0);
    glitch();
    issue(0, 0, 16'h8000, 16'h8000);
    glitch();
    for (int i = 0; i < 300; i++) begin
      issue(($urandom_range(0, 49) == 0), int'($urandom_range(0, 7)),
            pick(), pick());
    end
    issue(0, 4, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout left=%0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
